rtype_encoder: RTL and testbench
================================

Name: rtype_encoder

Overview:
- Inverse of the R-type control decode: takes a 4-bit ALU operation code plus register indices and assembles a legal 32-bit RV32I R-type instruction word.
- Results are buffered in a small FIFO with valid/ready handshakes on both sides.
- Feeds the instruction memory loader and self-test program generator so generated programs round-trip through the existing decoder.
- Illegal ALU codes are consumed, dropped and counted.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the encoded and illegal counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_alu_op  in  4  ALU control code to encode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- out_valid  out  1  instruction word available
- out_ready  in  1  consumer takes the word
- out_instr  out  32  encoded instruction (FIFO head)
- illegal_pulse  out  1  one-cycle flag: illegal code consumed this cycle
- encoded_count  out  CNT_W  number of words enqueued
- illegal_count  out  CNT_W  number of illegal codes dropped

Behaviour:
- Reset: sampled on the clock edge while reset=0. FIFO is emptied (pointers and occupancy 0). Outputs after reset: out_valid=0, in_ready=1, illegal_pulse=0, both counters=0. out_instr is don't-care while out_valid=0. A reset mid-operation discards all queued words.
- Word format: {funct7[6:0], rs2, rs1, funct3, rd, 7'b0110011}.
- Encoding table (alu_op -> funct3/funct7):
  - 0010 ADD -> 0/0x00
  - 0100 SUB -> 0/0x20
  - 0011 SLL -> 1/0x00
  - 1000 SLT -> 2/0x00
  - 1001 SLTU -> 3/0x00
  - 0111 XOR -> 4/0x00
  - 0101 SRL -> 5/0x00
  - 1010 SRA -> 5/0x20
  - 0001 OR -> 6/0x00
  - 0000 AND -> 7/0x00
- Illegal codes: 0110 and 1011-1111.
- Accept: occurs on a clock edge when in_valid=1 and in_ready=1.
- in_ready: equals !full, from the registered occupancy. It does not depend on out_ready in the same cycle, so a full FIFO with a simultaneous pop still refuses the push.
- Legal accept: the word is written at the tail and encoded_count increments.
- Illegal accept: nothing is written. illegal_pulse=1 for exactly the following cycle and illegal_count increments. in_ready behaves identically for legal and illegal codes.
- Pop: occurs when out_valid=1 and out_ready=1; the head advances. out_valid equals !empty.
- Latency: a word accepted at edge N is visible on out_instr/out_valid after edge N (a registered stage with no combinational bypass). Zero-occupancy push plus pop in the same cycle is therefore impossible.
- Push and pop in the same cycle (occupancy between 1 and DEPTH-1): occupancy is unchanged and order is preserved.
- Ordering: words are strictly first-in first-out. Pointers wrap modulo DEPTH.
- Stability: out_instr and out_valid hold stable while out_valid=1 and out_ready=0.
- Counters: wrap to 0 after reaching all-ones; no saturation.
- Invalid inputs: in_rd, in_rs1 and in_rs2 are ignored when in_valid=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> out_valid=0, in_ready=1, illegal_pulse=0, both counters 0.
- Single legal word: ADD, rd=1, rs1=2, rs2=3 with out_ready=1 -> out_instr=0x003100B3 one cycle later, encoded_count=1.
- Ordering: SUB (5,6,7), then SRA (31,31,31), then AND (0,0,0) back-to-back -> 0x407302B3, 0x41FFDFB3, 0x00007033 in order.
- Illegal code: alu_op=1111 -> no out_valid, illegal_pulse high for one cycle, illegal_count=1, encoded_count unchanged.
- Full and backpressure: out_ready=0, push DEPTH legal words -> in_ready=0 after the 4th. An extra in_valid is not accepted. Raise out_ready -> exactly 4 words drain in order and in_ready returns to 1.
- Reset mid-operation: with 3 words queued, drive reset=0 for one edge -> out_valid=0, counters 0, and the next push yields only the new word.
- Round-trip: encode all 10 legal codes and feed each word through the existing control decode -> alu_control equals the original in_alu_op and regwrite_control=1.

Source files
------------

// File: rtl/rtype_encoder.sv
// rtype_encoder: turns a 4-bit ALU control code plus register indices into an
// RV32I R-type instruction word and queues the result in a small FIFO.
// Illegal ALU codes are accepted, dropped, flagged for one cycle and counted.
module rtype_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] encoded_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);
    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_XOR  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_SRA  = 4'b1010
    } alu_op_e;

    logic [31:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;

    logic        legal;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;

    // Map the ALU control code to funct3/funct7 and flag codes with no encoding.
    always_comb begin
        legal  = 1'b1;
        funct3 = '0;
        funct7 = '0;
        case (in_alu_op)
            OP_ADD:  funct3 = 3'd0;
            OP_SUB:  begin funct3 = 3'd0; funct7 = 7'h20; end
            OP_SLL:  funct3 = 3'd1;
            OP_SLT:  funct3 = 3'd2;
            OP_SLTU: funct3 = 3'd3;
            OP_XOR:  funct3 = 3'd4;
            OP_SRL:  funct3 = 3'd5;
            OP_SRA:  begin funct3 = 3'd5; funct7 = 7'h20; end
            OP_OR:   funct3 = 3'd6;
            OP_AND:  funct3 = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    assign word      = {funct7, in_rs2, in_rs1, funct3, in_rd, OPCODE_OP};
    assign in_ready  = (level != FULL_LVL);
    assign out_valid = (level != '0);
    assign out_instr = mem[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    // Storage array; only legal accepted words are written at the tail.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Pointers, occupancy, illegal flag and statistics counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            illegal_pulse <= 1'b0;
            encoded_count <= '0;
            illegal_count <= '0;
        end else begin
            illegal_pulse <= accept && !legal;
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                encoded_count <= encoded_count + CNT_W'(1);
            end
            if (accept && !legal) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_encoder.sv
// tb_rtype_encoder: directed and randomized checks of rtype_encoder against a
// queue-based reference model built from the R-type encoding table.
module tb_rtype_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;   // narrow counters so wrap-around is exercised
    localparam int CMOD  = 1 << CNT_W;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_op;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             illegal_pulse;
    logic [CNT_W-1:0] encoded_count;
    logic [CNT_W-1:0] illegal_count;

    rtype_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .illegal_pulse(illegal_pulse),
        .encoded_count(encoded_count), .illegal_count(illegal_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Encoding table: alu_op, funct3, alternate (funct7 = 0x20) flag.
    int tbl_op [10] = '{2, 4, 3, 8, 9, 7, 5, 10, 1, 0};
    int tbl_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int tbl_alt[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};

    int n_vec;
    int n_err;

    logic [31:0] q[$];
    int          exp_enc;
    int          exp_ill;
    bit          exp_pulse;
    bit          armed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                      output logic [31:0] w);
        w = '0;
        for (int i = 0; i < 10; i++) begin
            if (tbl_op[i] == op) begin
                w = 32'(tbl_alt[i] * 32 * (2 ** 25) + rs2 * (2 ** 20) + rs1 * (2 ** 15)
                        + tbl_f3[i] * (2 ** 12) + rd * (2 ** 7) + 51);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Reference control decode: returns alu_control and regwrite for a word.
    function automatic void ref_decode(input logic [31:0] w, output int op, output bit regwrite);
        int f3, f7, opc;
        opc = int'(w) & 127;
        f3  = (int'(w >> 12)) & 7;
        f7  = (int'(w >> 25)) & 127;
        op = -1;
        regwrite = (opc == 51);
        for (int i = 0; i < 10; i++) begin
            if (tbl_f3[i] == f3 && f7 == (tbl_alt[i] ? 32 : 0)) op = tbl_op[i];
        end
    endfunction

    task automatic step();
        bit acc, pop, leg;
        logic [31:0] w;
        if (armed) check_eq("in_ready_pre", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
        acc = in_valid && (q.size() < DEPTH);
        pop = out_ready && (q.size() > 0);
        leg = ref_encode(int'(in_alu_op), int'(in_rd), int'(in_rs1), int'(in_rs2), w);
        @(posedge clock);
        #1;
        if (!reset) begin
            q.delete();
            exp_enc = 0; exp_ill = 0; exp_pulse = 0;
            armed = 1;
        end else begin
            exp_pulse = 0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (leg) begin
                    q.push_back(w);
                    exp_enc = (exp_enc + 1) % CMOD;
                end else begin
                    exp_ill = (exp_ill + 1) % CMOD;
                    exp_pulse = 1;
                end
            end
        end
        if (armed) begin
            check_eq("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) check_eq("out_instr", out_instr, q[0]);
            check_eq("illegal_pulse", {31'b0, illegal_pulse}, {31'b0, exp_pulse});
            check_eq("encoded_count", 32'(encoded_count), 32'(exp_enc));
            check_eq("illegal_count", 32'(illegal_count), 32'(exp_ill));
            check_eq("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
        end
    endtask

    task automatic push(input int op, input int rd, input int rs1, input int rs2);
        in_valid = 1; in_alu_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        step();
        in_valid = 0;
    endtask

    logic [31:0] order_exp [3];
    int  dop;
    bit  dreg;

    initial begin
        n_vec = 0; n_err = 0; armed = 0;
        exp_enc = 0; exp_ill = 0; exp_pulse = 0;
        reset = 0; in_valid = 0; out_ready = 0;
        in_alu_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;

        // Reset held for two edges.
        step(); step();
        reset = 1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single legal word.
        out_ready = 1;
        push(2, 1, 2, 3);
        check_eq("add_word", out_instr, 32'h003100B3);
        step();

        // Ordering of three queued words.
        out_ready = 0;
        push(4, 5, 6, 7); push(10, 31, 31, 31); push(0, 0, 0, 0);
        order_exp = '{32'h407302B3, 32'h41FFDFB3, 32'h00007033};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            check_eq("order_word", out_instr, order_exp[i]);
            step();
        end

        // Illegal code, then verify the pulse lasts one cycle.
        push(15, 3, 4, 5);
        check_eq("illegal_pulse_hi", {31'b0, illegal_pulse}, 32'd1);
        step();
        check_eq("illegal_pulse_lo", {31'b0, illegal_pulse}, 32'd0);

        // Fill under backpressure, attempt an extra push, then drain.
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) push(tbl_op[i], i + 1, i + 2, i + 3);
        check_eq("full_in_ready", {31'b0, in_ready}, 32'd0);
        push(2, 9, 9, 9);
        out_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        check_eq("drained_ready", {31'b0, in_ready}, 32'd1);

        // Reset mid-operation discards queued words.
        out_ready = 0;
        push(2, 4, 4, 4); push(4, 5, 5, 5); push(3, 6, 6, 6);
        reset = 0; step(); reset = 1;
        push(2, 1, 2, 3);
        check_eq("post_rst_word", out_instr, 32'h003100B3);
        out_ready = 1; step();

        // Round-trip every legal code through the reference decoder.
        for (int i = 0; i < 10; i++) begin
            push(tbl_op[i], $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            ref_decode(out_instr, dop, dreg);
            check_eq("rt_alu_control", 32'(dop), 32'(tbl_op[i]));
            check_eq("rt_regwrite", {31'b0, dreg}, 32'd1);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_alu_op = 4'($urandom_range(0, 15));
            in_rd     = 5'($urandom_range(0, 31));
            in_rs1    = 5'($urandom_range(0, 31));
            in_rs2    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 79) != 0);
            step();
        end
        reset = 1; in_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
